// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings and the packed command payload.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB_AB = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB_BA = 3'b010;
  localparam logic [OP_W-1:0] OP_OR     = 3'b011;
  localparam logic [OP_W-1:0] OP_AND    = 3'b100;
  localparam logic [OP_W-1:0] OP_XOR    = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR   = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP    = 3'b111;

  typedef struct packed {
    logic [OP_W-1:0]      oper;
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic DEPTH-entry synchronous FIFO (power-of-two DEPTH) with combinational head.
// Push on full and pop on empty are ignored.
module alu_cmd_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head_c,
  output logic              full_c,
  output logic              empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  assign head_c  = mem[rd_ptr];
  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: buffers ALU commands, drives the FIFO head into the ALU and registers tagged results.
// Optional: ALU_ILLEGAL_OP_TRAP_EN drops opcode 3'b111 at the input and raises sticky illegal_op.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_oper,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_oper,
  input  logic [WIDTH-1:0] alu_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [SEQ_W-1:0] res_seq,
  output logic             illegal_op
);

  // Same layout as alu_cmd_t, but sized by this instance's WIDTH.
  typedef struct packed {
    logic [OP_W-1:0]  oper;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t wr_cmd;
  cmd_t head;
  logic full;
  logic empty;
  logic push;
  logic wr_en;
  logic pop;
  logic seq_started;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!res_valid || res_ready);
  assign wr_cmd   = '{oper: in_oper, a: in_a, b: in_b};

`ifdef ALU_ILLEGAL_OP_TRAP_EN
  assign wr_en = push && (in_oper != OP_NOP);

  always_ff @(posedge clk) begin
    if (rst)                              illegal_op <= 1'b0;
    else if (push && (in_oper == OP_NOP)) illegal_op <= 1'b1;
  end
`else
  assign wr_en      = push;
  assign illegal_op = 1'b0;
`endif

  alu_cmd_fifo #(
    .DATA_W ($bits(cmd_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (wr_en),
    .pop     (pop),
    .wdata   (wr_cmd),
    .head_c  (head),
    .full_c  (full),
    .empty_c (empty)
  );

  // An empty queue presents NOP with zero operands so the ALU output is 0.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_oper = OP_NOP;
    if (!empty) begin
      alu_a    = head.a;
      alu_b    = head.b;
      alu_oper = head.oper;
    end
  end

  // Result slot; the tag stays at 0 for the first result after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_seq     <= '0;
      seq_started <= 1'b0;
    end else if (pop) begin
      res_valid   <= 1'b1;
      res_data    <= alu_sum;
      seq_started <= 1'b1;
      if (seq_started) res_seq <= res_seq + SEQ_W'(1);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage with an expected-result queue model.
// Honours ALU_ILLEGAL_OP_TRAP_EN the same way as the design.
module tb_alu_issue_stage;
  import alu_pkg::*;

`ifdef ALU_ILLEGAL_OP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_oper = 3'b000;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [2:0]  alu_oper;
  logic [63:0] alu_sum;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;
  logic [7:0]  res_seq;
  logic        illegal_op;

  int total = 0;
  int bad = 0;

  logic [63:0] exp_q[$];
  int          exp_seq = 0;
  int          cyc = 0;
  int          res_cnt = 0;
  int          mark = -1;
  int          mark_cyc = 0;
  int          last_cyc = 0;
  logic [63:0] last_data = '0;
  logic [7:0]  last_seq = '0;
  bit          hold_prev = 1'b0;
  logic [63:0] prev_data = '0;
  logic [7:0]  prev_seq = '0;

  always #5 clk = ~clk;

  // Behavioural 64-bit ALU, used both as the DUT's ALU and for expected results.
  function automatic logic [63:0] alu_ref(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB_AB: return a - b;
      OP_SUB_BA: return b - a;
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_XOR:    return a ^ b;
      OP_XNOR:   return ~(a ^ b);
      default:   return 64'd0;
    endcase
  endfunction

  assign alu_sum = alu_ref(alu_oper, alu_a, alu_b);

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_oper    (in_oper),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_oper   (alu_oper),
    .alu_sum    (alu_sum),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_seq    (res_seq),
    .illegal_op (illegal_op)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Negedge monitor: the handshakes seen here are the ones the next posedge commits.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_seq   = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", 64'(res_valid), 64'd1);
        check("stall_data", res_data, prev_data);
        check("stall_seq", 64'(res_seq), 64'(prev_seq));
      end
      if (in_valid && in_ready) begin
        if (!(TRAP_EN && in_oper == OP_NOP)) exp_q.push_back(alu_ref(in_oper, in_a, in_b));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_res", 64'd1, 64'd0);
        end else begin
          check("res_data", res_data, exp_q.pop_front());
          check("res_seq", 64'(res_seq), 64'(exp_seq));
          exp_seq = (exp_seq + 1) % 256;
        end
        if (res_cnt == mark) mark_cyc = cyc;
        res_cnt++;
        last_cyc  = cyc;
        last_data = res_data;
        last_seq  = res_seq;
      end
      hold_prev = res_valid && !res_ready;
      prev_data = res_data;
      prev_seq  = res_seq;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offers one command and returns just after the edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_oper  = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("send_timeout", 64'd1, 64'd0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 1000) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n >= 1000), 64'd0);
  endtask

  initial begin
    int base;
    int acc;

    do_reset();
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_seq", 64'(res_seq), 64'd0);
    check("rst_illegal", 64'(illegal_op), 64'd0);
    check("idle_alu_oper", 64'(alu_oper), 64'(OP_NOP));
    check("idle_alu_a", alu_a, 64'd0);

    // 1: single ADD, one-cycle latency
    res_ready = 1'b1;
    send(OP_ADD, 64'd5, 64'd3);
    check("t1_not_yet", 64'(res_valid), 64'd0);
    tick();
    check("t1_valid", 64'(res_valid), 64'd1);
    check("t1_data", res_data, 64'd8);
    check("t1_seq", 64'(res_seq), 64'd0);
    wait_drain();

    // 2: subtraction wrap both ways
    do_reset();
    send(OP_SUB_AB, 64'd0, 64'd1);
    send(OP_SUB_BA, 64'd0, 64'd1);
    wait_drain();
    check("t2_last_data", last_data, 64'd1);
    check("t2_last_seq", 64'(last_seq), 64'd1);

    // 3: backpressure fills slot + FIFO, then releases in order
    do_reset();
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_oper  = OP_ADD;
      in_a     = 64'(acc + 10);
      in_b     = 64'(i);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("t3_accepted", 64'(acc), 64'd5);
    check("t3_full", 64'(in_ready), 64'd0);
    base = res_cnt;
    mark = base;
    res_ready = 1'b1;
    #1;
    check("t3_ready_no_comb", 64'(in_ready), 64'd0);
    tick();
    check("t3_ready_back", 64'(in_ready), 64'd1);
    wait_drain();
    check("t3_count", 64'(res_cnt - base), 64'd5);
    check("t3_one_per_cycle", 64'(last_cyc - mark_cyc), 64'd4);

    // 4: 300 streamed XORs, no bubbles, tag wraps
    do_reset();
    base = res_cnt;
    mark = base;
    for (int i = 0; i < 300; i++) send(OP_XOR, {$urandom, $urandom}, {$urandom, $urandom});
    wait_drain();
    check("t4_count", 64'(res_cnt - base), 64'd300);
    check("t4_no_bubbles", 64'(last_cyc - mark_cyc), 64'd299);
    check("t4_last_seq", 64'(last_seq), 64'd43);

    // 5: reset mid-operation discards everything
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(OP_OR, 64'(i), 64'hF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_res_valid", 64'(res_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_res_seq", 64'(res_seq), 64'd0);
    check("t5_empty_oper", 64'(alu_oper), 64'(OP_NOP));
    res_ready = 1'b1;
    repeat (3) tick();
    check("t5_no_stale", 64'(res_valid), 64'd0);
    send(OP_ADD, 64'd1, 64'd1);
    wait_drain();
    check("t5_data", last_data, 64'd2);
    check("t5_seq", 64'(last_seq), 64'd0);

    // Random traffic with random result backpressure
    do_reset();
    base = res_cnt;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(3) == 0) tick();
          send(3'($urandom_range(6)), {$urandom, $urandom}, {$urandom, $urandom});
        end
      end
      begin
        for (int j = 0; j < 500; j++) begin
          res_ready = 1'($urandom_range(1));
          tick();
        end
        res_ready = 1'b1;
      end
    join
    wait_drain();
    check("rand_count", 64'(res_cnt - base), 64'd150);

    // 6: opcode 3'b111 handling
    do_reset();
    base = res_cnt;
    send(OP_OR, 64'h0C, 64'h03);
    send(OP_NOP, 64'd7, 64'd9);
    send(OP_AND, 64'h0F, 64'h3C);
    wait_drain();
    repeat (2) tick();
    check("t6_count", 64'(res_cnt - base), TRAP_EN ? 64'd2 : 64'd3);
    check("t6_last_seq", 64'(last_seq), TRAP_EN ? 64'd1 : 64'd2);
    check("t6_illegal", 64'(illegal_op), 64'(TRAP_EN));
    do_reset();
    check("t6_illegal_clr", 64'(illegal_op), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue stage for the 64-bit combinational ALU.
- Accepts {oper, a, b} commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU operand/opcode inputs, captures the ALU sum into a registered result slot with its own valid/ready handshake, and tags each result with a sequence number.
- Decouples the command producer from the result consumer at one command per cycle.

Parameters:
- WIDTH, 64, operand/result width.
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- SEQ_W, 8, result sequence-tag width.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  stage can accept a command.
- in_oper  input  3  ALU opcode.
- in_a  input  WIDTH  operand a.
- in_b  input  WIDTH  operand b.
- alu_a  output  WIDTH  to ALU a.
- alu_b  output  WIDTH  to ALU b.
- alu_oper  output  3  to ALU Oper.
- alu_sum  input  WIDTH  from ALU sum.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  registered result.
- res_seq  output  SEQ_W  result sequence tag.
- illegal_op  output  1  sticky illegal-opcode flag.

Behaviour:
- One clock (clk), synchronous active-high reset (rst). Reset clears count, write/read pointers, res_valid, res_data, res_seq and illegal_op to 0. FIFO storage is not reset.
- A reset asserted mid-operation discards all queued commands and any held result. The cycle after rst deasserts: in_ready=1, res_valid=0.
- in_ready = (count < DEPTH). It is a pure register decode with no combinational dependence on res_ready.
- Push = in_valid && in_ready; the entry is written at wr_ptr.
- Pop = (count != 0) && (!res_valid || res_ready).
- On pop: res_data <= alu_sum; res_valid <= 1; res_seq increments on every pop after the first since reset. The first result carries 0. The tag wraps 2^SEQ_W-1 -> 0.
- If res_valid && res_ready && !pop, then res_valid <= 0 and res_data holds.
- Pointers wrap modulo DEPTH. count += push - pop. Simultaneous push and pop leaves count unchanged.
- When full, in_ready=0 even if a pop occurs the same cycle; the freed slot is visible next cycle.
- ALU drive: alu_a/alu_b/alu_oper come combinationally from the head entry when count != 0. When empty they drive a=0, b=0, oper=3'b111, so the ALU output is 0.
- Latency: command accepted at edge N; result visible (res_valid=1) after edge N+1 if the result slot is free. Sustained throughput is 1 per cycle with res_ready held high.
- Width rule: res_data is exactly the WIDTH-bit ALU sum. Carry-out is not captured. Subtraction wraps modulo 2^WIDTH.
- Results leave in strict acceptance order.
- res_data and res_seq are stable while res_valid && !res_ready.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_TRAP_EN.
- Defined: a command with in_oper==3'b111 completes its handshake but is not written to the FIFO (no result, no seq increment). illegal_op is set the next cycle and stays 1 until rst.
- Undefined: 3'b111 is queued like any opcode and yields res_data=0 with a sequence tag. illegal_op is tied 0.

Decomposition:
- Shared package alu_pkg:
  - WIDTH_DEF=64 and OP_W=3.
  - Opcode constants OP_ADD=000, OP_SUB_AB=001, OP_SUB_BA=010, OP_OR=011, OP_AND=100, OP_XOR=101, OP_XNOR=110, OP_NOP=111.
  - Packed command typedef alu_cmd_t {oper, a, b}.
- One sub-module, alu_cmd_fifo: storage, pointers, count, full/empty. It is reused for result queues elsewhere.

Test Plan:
1. Idle, res_ready=1; push ADD a=5 b=3 -> res_valid=1 one cycle after acceptance, res_data=8, res_seq=0.
2. Push SUB_AB a=0 b=1, then SUB_BA a=0 b=1 -> res_data=0xFFFF_FFFF_FFFF_FFFF, then 0x1; res_seq=0, 1.
3. res_ready=0, DEPTH=4; offer 6 commands back-to-back -> 5 accepted (1 in result slot + 4 queued), in_ready=0 on the 6th. Raise res_ready -> 5 results in order, one per cycle, and in_ready returns the cycle after the first pop.
4. 300 XOR commands streamed with res_ready=1 -> one result per cycle after 1-cycle fill; res_seq runs 0..255, 0..43; no bubbles.
5. Queue 3 commands with res_ready=0, assert rst one cycle -> next cycle res_valid=0, in_ready=1, count=0, res_seq=0. A following ADD 1+1 yields res_data=2, res_seq=0.
6. Push OR, then oper=3'b111 a=7 b=9, then AND:
   - With ALU_ILLEGAL_OP_TRAP_EN: 2 results (seq 0, 1); illegal_op=1 sticky.
   - Without the macro: 3 results, the middle one res_data=0; illegal_op=0.
